// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - round-robin arbiter time-sharing one registered unsigned magnitude comparator
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b           packed operand pairs, requester i at [i*W +: W]
//   rsp_valid/rsp_ready    single response channel with backpressure
//   rsp_id                 requester index owning the response
//   rsp_gt/rsp_eq/rsp_lt   unsigned compare result, exactly one high with rsp_valid
//   busy                   registered, high outside IDLE
module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_gt,
  output logic              rsp_eq,
  output logic              rsp_lt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt, id_q;
  logic [ID_W-1:0] gnt_idx, cand;
  logic [ID_W:0]   cand_sum, ptr_sum;
  logic            gnt_found, accept;
  logic [W-1:0]    op_a, op_b, sel_a, sel_b;
  logic [W:0]      diff;

  // Rotating priority search: first valid requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NREQ))
        cand_sum = cand_sum - (ID_W+1)'(NREQ);
      cand = cand_sum[ID_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    ptr_sum = {1'b0, gnt_idx} + (ID_W+1)'(1);
    if (ptr_sum == (ID_W+1)'(NREQ))
      ptr_nxt = '0;
    else
      ptr_nxt = ptr_sum[ID_W-1:0];
  end

  // Operand select for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = CMP;
        end
      end
      CMP:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Borrow out of the widened subtraction is the unsigned "less than".
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      id_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rsp_gt <= 1'b0;
      rsp_eq <= 1'b0;
      rsp_lt <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= gnt_idx;
        ptr  <= ptr_nxt;
      end
      if (state == CMP) begin
        rsp_lt <= diff[W];
        rsp_eq <= (diff[W-1:0] == '0);
        rsp_gt <= !diff[W] && (diff[W-1:0] != '0);
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - directed scoreboard bench for cmp_share_arbiter
module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_gt, rsp_eq, rsp_lt, busy;

  cmp_share_arbiter #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic gt, eq, lt;
  } exp_t;

  exp_t            sb[$];
  logic [W-1:0]    ta[NREQ];
  logic [W-1:0]    tbv[NREQ];
  int              checks = 0;
  int              failures = 0;
  logic            oneshot = 1'b0;
  logic [NREQ-1:0] rr_seen;
  int              g_seen;
  int              gid[$];
  int              gcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ta[i] = a;
    tbv[i] = b;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Mid-cycle sample: record grants into the scoreboard and retire responses.
  task automatic samp();
    exp_t e;
    @(negedge clk);
    rr_seen = req_ready;
    g_seen = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_seen[i]) begin
        g_seen = i;
        e.id = ID_W'(i);
        e.gt = (ta[i] > tbv[i]);
        e.eq = (ta[i] == tbv[i]);
        e.lt = (ta[i] < tbv[i]);
        sb.push_back(e);
      end
    end
    if (rr_seen != '0)
      chk("rdy_onehot_valid", 32'(($countones(rr_seen) == 1) && ((rr_seen & ~req_valid) == '0)), 1);
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, {29'd0, e.gt, e.eq, e.lt});
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (oneshot) req_valid = req_valid & ~rr_seen;
  endtask

  task automatic cyc();
    samp();
    adv();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      cyc();
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    chk("drain", 32'(done), 1);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    set_op(0, 16'h0005, 16'h0003);
    set_op(1, 16'h0010, 16'h0020);
    set_op(2, 16'h0007, 16'h0007);
    set_op(3, 16'hFFFF, 16'h0000);
    oneshot = 1'b1;

    // Reset with every requester valid
    for (int n = 0; n < 2; n++) begin
      samp();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      adv();
    end
    rst = 1'b0;
    samp();
    chk("first_grant", g_seen, 0);
    adv();
    req_valid = '0;
    wait_idle();

    // Single requester, latency and result
    set_op(2, 16'h1234, 16'h1233);
    req_valid = 4'b0100;
    samp();
    chk("single_ready", 32'(req_ready), 32'b0100);
    adv();
    samp();
    chk("single_cmp_valid", 32'(rsp_valid), 0);
    chk("single_cmp_busy", 32'(busy), 1);
    adv();
    samp();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 2);
    chk("single_rsp_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'b100);
    adv();
    set_op(2, 16'h00FF, 16'h00FF);
    req_valid = 4'b0100;
    wait_idle();
    set_op(2, 16'h0000, 16'hFFFF);
    req_valid = 4'b0100;
    wait_idle();

    // Fairness with all requests held valid from ptr=0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'h1000 * i + 16'h0005, 16'h2005);
    oneshot = 1'b0;
    req_valid = '1;
    for (int n = 0; n < 18; n++) begin
      samp();
      if (g_seen >= 0) begin
        gid.push_back(g_seen);
        gcyc.push_back(n);
      end
      adv();
    end
    req_valid = '0;
    wait_idle();
    chk("fair_count", 32'(gid.size()), 6);
    for (int j = 0; j < gid.size() && j < 6; j++) begin
      chk("fair_id", gid[j], j % NREQ);
      chk("fair_interval", gcyc[j], 3 * j);
    end

    // Backpressure with other requests pending (ptr=2)
    oneshot = 1'b1;
    set_op(2, 16'h0001, 16'h0002);
    req_valid = '1;
    rsp_ready = 1'b0;
    samp();
    chk("bp_grant", g_seen, 2);
    adv();
    cyc();
    for (int n = 0; n < 5; n++) begin
      samp();
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_rsp_id", 32'(rsp_id), 2);
      chk("bp_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'b001);
      adv();
    end
    rsp_ready = 1'b1;
    cyc();
    samp();
    chk("bp_next_grant", g_seen, 3);
    adv();
    req_valid = '0;
    wait_idle();

    // Pointer wrap: move ptr to 3, then only requester 1
    req_valid = 4'b0100;
    samp();
    chk("wrap_setup_grant", g_seen, 2);
    adv();
    wait_idle();
    req_valid = 4'b0010;
    samp();
    chk("wrap_grant1", g_seen, 1);
    adv();
    wait_idle();
    req_valid = 4'b1001;
    samp();
    chk("wrap_grant3_first", g_seen, 3);
    adv();
    cyc();
    cyc();
    samp();
    chk("wrap_grant0_second", g_seen, 0);
    adv();
    wait_idle();

    // Reset during RESP abandons the transaction
    set_op(1, 16'h8000, 16'h7FFF);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    samp();
    chk("mid_grant", g_seen, 1);
    adv();
    cyc();
    rst = 1'b1;
    samp();
    chk("mid_rsp_valid", 32'(rsp_valid), 1);
    chk("mid_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'b100);
    adv();
    sb.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      samp();
      chk("mid_no_stale", 32'(rsp_valid), 0);
      adv();
    end
    req_valid = 4'b1001;
    samp();
    chk("mid_restart_grant", g_seen, 0);
    adv();
    req_valid = '0;
    wait_idle();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Round-robin arbiter and sequencer that time-shares one registered 16-bit magnitude comparator between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands and computes the result. It then returns gt/eq/lt, tagged with the requester ID, on a single response channel with backpressure. It sits between the compare-using clients and the shared comparator datapath.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- W, 16, operand width in bits.
- ID_W, derived $clog2(NREQ), width of the requester ID.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  bit i is high when requester i has an operand pair pending.
- req_a  in  NREQ*W  packed operand A; requester i occupies [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i's pair is accepted this cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_gt, rsp_eq, rsp_lt  out  1 each  unsigned A>B, A==B, A<B; exactly one is high while rsp_valid is high.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: no request in flight.
  - CMP: operands latched, compare in progress.
  - RESP: result held on the response channel.
- IDLE: if any req_valid bit is set, grant the first set bit at or after the pointer ptr, searching upward and wrapping modulo NREQ.
  - req_ready[g] is high in the same cycle. It is combinational from req_valid, ptr and state, and is zero outside IDLE.
  - On that edge, latch req_a/req_b slice g into op_a/op_b and g into id_q.
  - ptr becomes (g+1) mod NREQ; state goes to CMP.
- IDLE with no valid request: stay in IDLE; ptr is unchanged.
- CMP: compute {borrow, diff} = {1'b0,op_a} - {1'b0,op_b} at W+1 bits.
  - lt = borrow; eq = (diff[W-1:0]==0); gt = !borrow & !eq.
  - Register the results into rsp_gt/eq/lt; state goes to RESP.
- RESP: rsp_valid=1. rsp_id, rsp_gt, rsp_eq and rsp_lt stay stable until rsp_ready is sampled high; then state goes to IDLE.
- Comparison is strictly unsigned across the full W bits. 0x0000 vs 0xFFFF gives lt, and 0x8000 vs 0x7FFF gives gt.
- Requests from non-granted requesters are not consumed. They must remain asserted until their own req_ready; the block never drops or reorders within one requester.
- Round-robin fairness: with all NREQ requests held valid, grants cycle 0,1,…,NREQ-1,0 with no requester skipped.
- A requester that lowers req_valid before being granted is simply not granted. No state is retained for it.

## Timing
- Reset (rst high at an edge):
  - state=IDLE, ptr=0.
  - rsp_valid=0, rsp_gt=rsp_eq=rsp_lt=0, rsp_id=0, busy=0.
  - req_ready=0 while rst is high.
- Reset mid-operation (in CMP or RESP) abandons the transaction. No response is produced for it, and the next grant starts from requester 0.
- Latency: accept at edge t, then CMP during cycle t+1. rsp_valid is first high in cycle t+2.
- With rsp_ready held high: the response handshake completes at edge t+3, and the next accept is at the earliest in cycle t+3. Minimum issue interval is 3 cycles.
- Backpressure: each cycle of rsp_ready=0 in RESP extends the transaction by one cycle. Outputs are held bit-stable and all req_ready stay 0.
- Simultaneous requests in IDLE: exactly one grant per cycle, chosen per the ptr rule.
- busy is registered: 1 in CMP and RESP, 0 in IDLE.

## Test plan
- Reset: apply rst for 2 cycles with all req_valid=1. Required: req_ready=0, rsp_valid=0, busy=0. After release, the first grant goes to requester 0.
- Single requester: requester 2 sends A=0x1234, B=0x1233, rsp_ready=1. Required:
  - req_ready=0b0100 in the accept cycle.
  - rsp_valid two cycles later with rsp_id=2, gt=1, eq=0, lt=0.
  - Then send 0x00FF/0x00FF (eq=1) and 0x0000/0xFFFF (lt=1).
- Fairness: all 4 requesters valid continuously, each with a distinct A. Required: rsp_id sequence 0,1,2,3,0,1 at one response per 3 cycles; the results match the unsigned compare of each pair.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with other requests pending. Required: rsp_* stable, all req_ready=0, busy=1; the handshake completes on the first cycle rsp_ready=1.
- Pointer wrap: ptr at 3, only requester 1 valid. Required: requester 1 is granted and ptr becomes 2. Then requesters 0 and 3 are valid; required: requester 3 is granted before requester 0.
- Reset mid-operation: assert rst in the RESP cycle for 0x8000/0x7FFF. Required: rsp_valid drops the next cycle and no stale response appears afterwards.
